// File: rtl/jtopl_pkg.sv
// Shared definitions for the operator register ring: register group codes,
// readback FSM states and the error byte returned on a failed read.
package jtopl_pkg;

    localparam logic [2:0] GRP_MULT  = 3'd1;
    localparam logic [2:0] GRP_KSLTL = 3'd2;
    localparam logic [2:0] GRP_ARDR  = 3'd3;
    localparam logic [2:0] GRP_SLRR  = 3'd4;
    localparam logic [2:0] GRP_WAV   = 3'd7;

    localparam logic [7:0] ERR_DATA  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHK,
        ST_WAIT,
        ST_DONE
    } rd_state_e;

    function automatic logic grp_known(input logic [2:0] grp);
        logic known;
        case (grp)
            GRP_MULT, GRP_KSLTL, GRP_ARDR, GRP_SLRR, GRP_WAV: known = 1'b1;
            default:                                          known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/jtopl_opaddr.sv
// Maps the low five bits of an operator register address to a ring slot.
// Each 8-address row holds 6 operators; offsets 6/7 of a row and 0x16+ are holes.
module jtopl_opaddr (
    input  logic [4:0] i_off,
    output logic       o_valid,
    output logic [4:0] o_op
);

    logic [4:0] w_row_base;

    assign w_row_base = {1'b0, i_off[4:3], 2'b00} + {2'b00, i_off[4:3], 1'b0};
    assign o_valid    = (i_off < 5'h16) && (i_off[2:0] < 3'd6);
    assign o_op       = w_row_base + {2'b00, i_off[2:0]};

endmodule

// File: rtl/jtopl_csr_rd.sv
// CPU readback of one byte of an operator's register word, taken from the ring
// output when the addressed operator's slot comes round. Passive tap on the ring.
module jtopl_csr_rd
    import jtopl_pkg::*;
#(
    parameter int LEN  = 18,
    parameter int W    = 34,
    parameter int TOUT = 2 * LEN
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_cen,
    input  logic [W-1:0] i_shift_out,
    input  logic [4:0]   i_slot,
    input  logic         i_rd_req,
    input  logic [7:0]   i_rd_addr,
    output logic         o_busy,
    output logic         o_rd_valid,
    output logic [7:0]   o_rd_data,
    output logic         o_rd_err
);

    localparam int CW = $clog2(TOUT);

    rd_state_e   r_state;
    rd_state_e   w_state_nxt;
    logic [2:0]  r_grp;
    logic [4:0]  r_op;
    logic        r_bad;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [7:0]  r_res_data;
    logic [7:0]  w_res_data_nxt;
    logic        r_res_err;
    logic        w_res_err_nxt;
    logic        w_latch;
    logic        r_rd_valid;
    logic [7:0]  r_rd_data;
    logic        r_rd_err;

    logic        w_off_ok;
    logic [4:0]  w_op;
    logic        w_bad;
    logic [1:0]  w_wav;
    logic [7:0]  w_field;

    jtopl_opaddr u_opaddr (
        .i_off   (i_rd_addr[4:0]),
        .o_valid (w_off_ok),
        .o_op    (w_op)
    );

    assign w_bad = !w_off_ok || !grp_known(i_rd_addr[7:5]) || (int'(w_op) >= LEN);

    // Narrow rings carry no waveform field; those reads return zero.
    if (W >= 34) begin : g_wav
        assign w_wav = i_shift_out[33:32];
    end else begin : g_nowav
        assign w_wav = 2'b00;
    end

    always_comb begin
        w_field = 8'h00;
        case (r_grp)
            GRP_MULT:  w_field = i_shift_out[31:24];
            GRP_KSLTL: w_field = i_shift_out[23:16];
            GRP_ARDR:  w_field = i_shift_out[15:8];
            GRP_SLRR:  w_field = i_shift_out[7:0];
            GRP_WAV:   w_field = {6'b000000, w_wav};
            default:   w_field = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_res_data_nxt = r_res_data;
        w_res_err_nxt  = r_res_err;
        w_latch        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rd_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                if (r_bad) begin
                    w_res_data_nxt = ERR_DATA;
                    w_res_err_nxt  = 1'b1;
                    w_state_nxt    = ST_DONE;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Only ring advances count as chances to see the operator.
                if (i_cen) begin
                    if (i_slot == r_op) begin
                        w_res_data_nxt = w_field;
                        w_res_err_nxt  = 1'b0;
                        w_state_nxt    = ST_DONE;
                    end else if (r_cnt == CW'(TOUT - 1)) begin
                        w_res_data_nxt = ERR_DATA;
                        w_res_err_nxt  = 1'b1;
                        w_state_nxt    = ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_grp      <= 3'd0;
            r_op       <= 5'd0;
            r_bad      <= 1'b0;
            r_cnt      <= '0;
            r_res_data <= 8'h00;
            r_res_err  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
            r_rd_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_res_data <= w_res_data_nxt;
            r_res_err  <= w_res_err_nxt;
            if (w_latch) begin
                r_grp <= i_rd_addr[7:5];
                r_op  <= w_op;
                r_bad <= w_bad;
            end
            // Result is published on the DONE->IDLE edge, so rd_data only moves with rd_valid.
            r_rd_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_rd_data <= r_res_data;
                r_rd_err  <= r_res_err;
            end
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_rd_err   = r_rd_err;

endmodule
